// File: rtl/cmd_parser_pkg.sv
// Shared definitions for the command parser: FSM encoding, response codes
// and the default start-of-frame byte.
package cmd_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_CMD  = 2'd1,
    ST_GET_CHK  = 2'd2,
    ST_SEND_RSP = 2'd3
  } state_t;

  localparam logic [7:0] RSP_ACK     = 8'h06;
  localparam logic [7:0] RSP_NAK     = 8'h15;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/cmd_parser.sv
// Three-byte command frame parser (SOF, CMD, ~CMD) with ACK/NAK response,
// inter-byte timeout and a saturating rejected-frame counter.
//   state       | meaning
//   ST_IDLE     | hunting for SOF, other bytes dropped
//   ST_GET_CMD  | next byte is the candidate command
//   ST_GET_CHK  | next byte must equal ~candidate
//   ST_SEND_RSP | holding ACK/NAK on tx until accepted
module cmd_parser
  import cmd_parser_pkg::*;
#(
  parameter logic [7:0]  DEF_CMD = 8'd52,
  parameter logic [7:0]  SOF     = SOF_DEFAULT,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] cmd,
  output logic       cmd_stb,
  output logic [7:0] err_cnt
);

  state_t      state_q, state_d;
  logic [7:0]  cand_q, cand_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        stb_q, stb_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        err_inc;
  logic        rx_fire, tx_fire, to_hit;

  assign rx_ready = (state_q != ST_SEND_RSP);
  assign tx_valid = (state_q == ST_SEND_RSP);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign to_hit   = (to_cnt_q == (TIMEOUT - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cand_q    <= 8'h00;
      cmd_q     <= DEF_CMD;
      stb_q     <= 1'b0;
      tx_data_q <= 8'h00;
      err_q     <= 8'h00;
      to_cnt_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cmd_q     <= cmd_d;
      stb_q     <= stb_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cmd_d     = cmd_q;
    stb_d     = 1'b0;
    tx_data_d = tx_data_q;
    to_cnt_d  = to_cnt_q;
    err_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = 16'h0000;
        if (rx_fire && (rx_data == SOF)) state_d = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        // An accepted byte always beats a coincident timeout.
        if (rx_fire) begin
          cand_d   = rx_data;
          to_cnt_d = 16'h0000;
          state_d  = ST_GET_CHK;
        end else if (to_hit) begin
          to_cnt_d = 16'h0000;
          err_inc  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_GET_CHK: begin
        if (rx_fire) begin
          to_cnt_d = 16'h0000;
          state_d  = ST_SEND_RSP;
          if (rx_data == ~cand_q) begin
            cmd_d     = cand_q;
            stb_d     = 1'b1;
            tx_data_d = RSP_ACK;
          end else begin
            err_inc   = 1'b1;
            tx_data_d = RSP_NAK;
          end
        end else if (to_hit) begin
          to_cnt_d = 16'h0000;
          err_inc  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_SEND_RSP: begin
        to_cnt_d = 16'h0000;
        if (tx_fire) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        to_cnt_d = 16'h0000;
      end
    endcase

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  assign tx_data = tx_data_q;
  assign cmd     = cmd_q;
  assign cmd_stb = stb_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cmd_parser;

  localparam logic [15:0] TO = 16'd64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] cmd;
  logic       cmd_stb;
  logic [7:0] err_cnt;

  cmd_parser #(.DEF_CMD(8'd52), .SOF(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd(cmd), .cmd_stb(cmd_stb), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes gathered so far, pending response, error total.
  int         m_phase;  // frame bytes held: 0 none, 1 SOF, 2 SOF+CMD
  int         m_idle;
  int         m_err;
  logic [7:0] m_cand, m_cmd, m_rsp;
  logic       m_busy, m_stb;
  logic [7:0] last_tx = 8'h00;

  function automatic logic [7:0] sat_err(input int e);
    return (e > 255) ? 8'hFF : 8'(e);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_idle = 0; m_err = 0; m_cand = 8'h00;
      m_cmd = 8'd52; m_rsp = 8'h00; m_busy = 1'b0; m_stb = 1'b0;
    end
    chk("rx_ready", 8'(rx_ready), 8'(!m_busy));
    chk("tx_valid", 8'(tx_valid), 8'(m_busy));
    chk("tx_data",  tx_data, m_rsp);
    chk("cmd",      cmd, m_cmd);
    chk("cmd_stb",  8'(cmd_stb), 8'(m_stb));
    chk("err_cnt",  err_cnt, sat_err(m_err));
    if (!rst) begin
      m_stb = 1'b0;
      if (m_busy) begin
        if (tx_ready) begin
          last_tx = m_rsp;
          m_busy  = 1'b0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        if (m_phase == 0) begin
          if (rx_data == 8'hA5) m_phase = 1;
        end else if (m_phase == 1) begin
          m_cand  = rx_data;
          m_phase = 2;
        end else begin
          if ((rx_data ^ m_cand) == 8'hFF) begin
            m_cmd = m_cand; m_stb = 1'b1; m_rsp = 8'h06;
          end else begin
            m_err++; m_rsp = 8'h15;
          end
          m_busy  = 1'b1;
          m_phase = 0;
        end
      end else if (m_phase != 0) begin
        m_idle++;
        if (m_idle == int'(TO)) begin
          m_phase = 0; m_idle = 0; m_err++;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    rx_valid = 1'b0;
    if (!done) chk("send_timeout", 8'd0, 8'd1);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd"},      cmd, 8'd52);
    chk({tag, "_err"},      err_cnt, 8'h00);
    chk({tag, "_stb"},      8'(cmd_stb), 8'd0);
    chk({tag, "_txv"},      8'(tx_valid), 8'd0);
    chk({tag, "_txd"},      tx_data, 8'h00);
    chk({tag, "_rxr"},      8'(rx_ready), 8'd1);
  endtask

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    chk_reset_vals("reset");

    // Valid frame: strobe and ACK visible in cycle N+3
    send_frame(8'hA5, 8'h34, 8'hCB);
    chk("valid_stb", 8'(cmd_stb), 8'd1);
    chk("valid_txv", 8'(tx_valid), 8'd1);
    chk("valid_txd", tx_data, 8'h06);
    chk("valid_cmd", cmd, 8'h34);
    wait_cycles(1);
    chk("valid_stb_off", 8'(cmd_stb), 8'd0);
    chk("valid_txv_off", 8'(tx_valid), 8'd0);
    chk("valid_err", err_cnt, 8'h00);
    chk("valid_last_tx", last_tx, 8'h06);

    // Bad checksum
    do_reset();
    send_frame(8'hA5, 8'h34, 8'h00);
    chk("bad_stb", 8'(cmd_stb), 8'd0);
    chk("bad_txd", tx_data, 8'h15);
    wait_cycles(1);
    chk("bad_cmd", cmd, 8'd52);
    chk("bad_err", err_cnt, 8'h01);
    chk("bad_last_tx", last_tx, 8'h15);

    // Stalled frame times out after TO idle cycles
    do_reset();
    send_byte(8'hA5); send_byte(8'h34);
    wait_cycles(int'(TO));
    chk("to_err", err_cnt, 8'h01);
    chk("to_txv", 8'(tx_valid), 8'd0);
    chk("to_rxr", 8'(rx_ready), 8'd1);
    send_frame(8'hA5, 8'h10, 8'hEF);
    wait_cycles(1);
    chk("to_next_cmd", cmd, 8'h10);
    // Byte arriving on the last allowed idle cycle wins over the timeout
    send_byte(8'hA5); send_byte(8'h20);
    wait_cycles(int'(TO) - 1);
    send_byte(8'hDF);
    wait_cycles(1);
    chk("to_edge_cmd", cmd, 8'h20);
    chk("to_edge_err", err_cnt, 8'h01);

    // Backpressure on the response
    tx_ready = 1'b0;
    send_frame(8'hA5, 8'h34, 8'hCB);
    rx_valid = 1'b1; rx_data = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      chk("bp_txv", 8'(tx_valid), 8'd1);
      chk("bp_txd", tx_data, 8'h06);
      chk("bp_rxr", 8'(rx_ready), 8'd0);
      wait_cycles(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_cycles(1);
    chk("bp_done_txv", 8'(tx_valid), 8'd0);
    chk("bp_done_rxr", 8'(rx_ready), 8'd1);
    chk("bp_cmd", cmd, 8'h34);

    // Junk before SOF, SOF value as the command payload
    do_reset();
    send_byte(8'h00); send_byte(8'hFF);
    send_frame(8'hA5, 8'hA5, 8'h5A);
    chk("junk_stb", 8'(cmd_stb), 8'd1);
    chk("junk_txd", tx_data, 8'h06);
    wait_cycles(1);
    chk("junk_cmd", cmd, 8'hA5);
    chk("junk_err", err_cnt, 8'h00);

    // Saturation
    do_reset();
    for (int i = 0; i < 300; i++) send_frame(8'hA5, 8'h00, 8'h00);
    wait_cycles(2);
    chk("sat_err", err_cnt, 8'hFF);

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h77);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_frame");
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);

    // Reset mid-response
    tx_ready = 1'b0;
    send_frame(8'hA5, 8'h34, 8'hCB);
    wait_cycles(2);
    chk("pre_rst_txv", 8'(tx_valid), 8'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_rsp");
    wait_cycles(2);
    rst = 1'b0;
    tx_ready = 1'b1;
    wait_cycles(3);
    chk("post_rst_cmd", cmd, 8'd52);
    chk("post_rst_txv", 8'(tx_valid), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameters (name, default, meaning); parameter values are sized constants:
- DEF_CMD, 8'd52: command held on cmd after reset.
- SOF, 8'hA5: start-of-frame byte.
- TIMEOUT, 16'd50000: idle cycles allowed between bytes of one frame.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- rx_data, in, 8: byte from USB receive side.
- rx_valid, in, 1: rx_data valid.
- rx_ready, out, 1: parser accepts byte.
- tx_data, out, 8: response byte to USB transmit side.
- tx_valid, out, 1: tx_data valid.
- tx_ready, in, 1: transmit side accepts byte.
- cmd, out, 8: current command, feeds state selector.
- cmd_stb, out, 1: one-cycle pulse when cmd updates.
- err_cnt, out, 8: count of rejected frames, saturating.

Function
REQ-003 A byte transfers on a clk edge with rx_valid=1 and rx_ready=1; a response transfers on an edge with tx_valid=1 and tx_ready=1.
REQ-004 Frame format: SOF, CMD, CHK; a frame is valid iff CHK == bitwise NOT of CMD.
REQ-005 FSM states: IDLE, GET_CMD, GET_CHK, SEND_RSP.
REQ-006 IDLE: accepted byte == SOF -> GET_CMD; any other byte is discarded, state unchanged, err_cnt unchanged.
REQ-007 GET_CMD: accepted byte is latched as candidate, regardless of value (0xA5 included) -> GET_CHK.
REQ-008 GET_CHK: accepted byte checked per REQ-004 -> SEND_RSP.
- Valid: cmd <= candidate and cmd_stb=1 on the cycle after acceptance; response 8'h06.
- Invalid: cmd unchanged, no strobe, err_cnt incremented; response 8'h15.
REQ-009 SEND_RSP: tx_valid=1 and tx_data stable until transfer; rx_ready=0; on transfer -> IDLE.
REQ-010 rx_ready=1 in IDLE, GET_CMD and GET_CHK.
REQ-011 Timeout counter: cleared on every accepted byte and when entering GET_CMD; increments each cycle in GET_CMD/GET_CHK without an accepted byte.
REQ-012 When the timeout counter reaches TIMEOUT-1 with no byte accepted that cycle: -> IDLE, err_cnt incremented, no response, cmd unchanged.
REQ-013 Timeout and byte acceptance in the same cycle: the byte wins and the timeout is ignored.
REQ-014 err_cnt saturates at 8'hFF and never wraps.
REQ-015 Latency: SOF at edge N, CMD at N+1, CHK at N+2 -> cmd_stb high and tx_valid high during cycle N+3.
REQ-016 cmd_stb is never high for more than one consecutive cycle.
REQ-017 tx_valid, once asserted, is not deasserted before transfer.

Reset
REQ-018 During rst=1 and after release:
- state IDLE, cmd=DEF_CMD, cmd_stb=0, tx_valid=0, tx_data=8'h00, err_cnt=0, timeout counter=0, candidate register=0.
REQ-019 rst assertion mid-frame or mid-response abandons the frame immediately, with no response and no cmd change beyond the reset value.

Structure
REQ-020 A shared package holds: the FSM state encoding, the ACK (8'h06) and NAK (8'h15) constants, and the default SOF value.
REQ-021 The implementation is a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-022 Valid frame: reset, then A5,34,CB back-to-back with tx_ready=1 -> cmd=8'h34, one cmd_stb pulse at N+3, tx byte 8'h06, err_cnt=0.
REQ-023 Bad checksum: A5,34,00 -> cmd stays 8'd52, no cmd_stb, tx byte 8'h15, err_cnt=1.
REQ-024 Stalled frame: A5,34, then idle for TIMEOUT cycles -> state IDLE, err_cnt=1, no tx_valid; a following A5,10,EF yields cmd=8'h10.
REQ-025 Backpressure: valid frame with tx_ready=0 for 20 cycles -> tx_valid and tx_data 8'h06 held, rx_ready=0 throughout; transfer on the first tx_ready=1 edge, then rx_ready=1.
REQ-026 Junk and SOF as payload: 00,FF,A5,A5,5A -> junk bytes ignored, cmd=8'hA5, ACK returned.
REQ-027 Saturation and reset: 300 bad frames -> err_cnt=8'hFF; rst pulse mid-frame -> all outputs return to their reset values immediately.
